// File: rtl/pe_array_sched_pkg.sv
// Shared types and default sizing for the PE-array column scheduler.
package pe_sched_pkg;

  localparam int NUM_PE      = 8;
  localparam int COL_W       = 5;
  localparam int X_BASE      = 16;
  localparam int TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE,
    RESULT,
    CLEAR,
    DONE
  } sched_state_e;

endpackage

// File: rtl/pe_array_sched_watchdog.sv
// Per-phase watchdog.
// Counts cycles while enabled and is restarted by clear.
// Flags expiry on the cycle whose edge would bring the count to TIMEOUT_CYC.
module pe_watchdog #(
  parameter int TIMEOUT_CYC = pe_sched_pkg::TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  import pe_sched_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear, otherwise count up while enabled and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CW'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry depends only on the registered count, so the scheduler can use it in next-state logic.
  // That logic also drives clear, and this keeps the path free of a combinational loop.
  assign expire = enable && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pe_array_sched.sv
// Column scheduler for the PE vector array.
// Walks the output columns and enables the PEs until every PE reports valid.
// Hands each column result downstream, then waits for the PEs to clear before advancing.
module pe_array_sched #(
  parameter int NUM_PE      = pe_sched_pkg::NUM_PE,
  parameter int COL_W       = pe_sched_pkg::COL_W,
  parameter int X_BASE      = pe_sched_pkg::X_BASE,
  parameter int TIMEOUT_CYC = pe_sched_pkg::TIMEOUT_CYC
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              abort,
  input  logic [COL_W:0]    num_cols,
  input  logic [NUM_PE-1:0] pe_valid,
  input  logic              res_ready,
  output logic              pe_enable,
  output logic [COL_W-1:0]  col_idx,
  output logic              k_bank_sel,
  output logic [COL_W-1:0]  x_addr,
  output logic              res_valid,
  output logic [COL_W-1:0]  res_col,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);
  import pe_sched_pkg::*;

  localparam int NUM_COLS = 2 ** COL_W;

  sched_state_e   state_q, state_d;
  logic [COL_W:0]   count_q, count_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [COL_W-1:0] res_col_q, res_col_d;
  logic             timeout_err_q, timeout_err_d;
  logic             pe_enable_q, pe_enable_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic           wd_clear;
  logic           wd_enable;
  logic           wd_expire;
  logic [COL_W:0] eff_count;
  logic           is_last;

  // A latched count of zero means a full sweep.
  // The last column is also capped at NUM_COLS-1 so col_idx can never wrap.
  assign eff_count = (count_q == '0) ? (COL_W + 1)'(NUM_COLS) : count_q;
  assign is_last   = (({1'b0, col_idx_q} + (COL_W + 1)'(1)) >= eff_count) ||
                     (col_idx_q == COL_W'(NUM_COLS - 1));

  // Next-state logic.
  // Priority order: abort, then watchdog expiry, then normal progress.
  // Registered outputs are derived from the next state.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    col_idx_d     = col_idx_q;
    res_col_d     = res_col_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d       = COMPUTE;
          count_d       = num_cols;
          col_idx_d     = '0;
          timeout_err_d = 1'b0;
        end
      end
      COMPUTE: begin
        if (abort) begin
          state_d = DONE;
        end else if (wd_expire) begin
          state_d       = DONE;
          timeout_err_d = 1'b1;
        end else if (&pe_valid) begin
          state_d   = RESULT;
          res_col_d = col_idx_q;
        end
      end
      RESULT: begin
        if (abort) begin
          state_d = DONE;
        end else if (res_ready) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = DONE;
        end else if (wd_expire) begin
          state_d       = DONE;
          timeout_err_d = 1'b1;
        end else if (pe_valid == '0) begin
          if (is_last) begin
            state_d = DONE;
          end else begin
            state_d   = COMPUTE;
            col_idx_d = col_idx_q + COL_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pe_enable_d = (state_d == COMPUTE);
    res_valid_d = (state_d == RESULT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // The watchdog restarts on every state change.
  // It only counts while the scheduler waits on the PEs.
  assign wd_clear  = (state_d != state_q);
  assign wd_enable = (state_q == COMPUTE) || (state_q == CLEAR);

  pe_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (CLK),
    .reset (RESET),
    .clear (wd_clear),
    .enable(wd_enable),
    .expire(wd_expire)
  );

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      count_q       <= '0;
      col_idx_q     <= '0;
      res_col_q     <= '0;
      timeout_err_q <= 1'b0;
      pe_enable_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      col_idx_q     <= col_idx_d;
      res_col_q     <= res_col_d;
      timeout_err_q <= timeout_err_d;
      pe_enable_q   <= pe_enable_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Memory addressing follows the registered column while a run is active.
  // It reads as zero when idle, so reset leaves every output at zero.
  assign k_bank_sel  = busy_q & col_idx_q[0];
  assign x_addr      = busy_q ? (COL_W'(X_BASE) + (col_idx_q >> 1)) : '0;
  assign pe_enable   = pe_enable_q;
  assign col_idx     = col_idx_q;
  assign res_valid   = res_valid_q;
  assign res_col     = res_col_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed testbench for pe_array_sched.
// A behavioural PE model answers the enable, and hand-computed expectations are checked.
module tb_pe_array_sched;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic       abort;
  logic [5:0] num_cols;
  logic [7:0] pe_valid = 8'h00;
  logic       res_ready;
  logic       pe_enable;
  logic [4:0] col_idx;
  logic       k_bank_sel;
  logic [4:0] x_addr;
  logic       res_valid;
  logic [4:0] res_col;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  bit         pe_model_on = 1'b1;
  int         pe_lat = 3;
  logic [7:0] pe_stuck = 8'h00;
  int         en_cnt = 0;

  logic [4:0] cq[$];
  logic       bq[$];
  logic [4:0] xq[$];

  pe_array_sched #(
    .NUM_PE(8),
    .COL_W(5),
    .X_BASE(16),
    .TIMEOUT_CYC(16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .abort      (abort),
    .num_cols   (num_cols),
    .pe_valid   (pe_valid),
    .res_ready  (res_ready),
    .pe_enable  (pe_enable),
    .col_idx    (col_idx),
    .k_bank_sel (k_bank_sel),
    .x_addr     (x_addr),
    .res_valid  (res_valid),
    .res_col    (res_col),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  // PE model: all PEs go valid pe_lat edges after enable rises and drop valid once enable falls.
  // When the model is off, pe_valid is held at pe_stuck.
  always @(posedge CLK) begin
    if (!pe_model_on) begin
      pe_valid <= pe_stuck;
      en_cnt   <= 0;
    end else if (pe_enable) begin
      en_cnt <= en_cnt + 1;
      if (en_cnt + 1 >= pe_lat) pe_valid <= 8'hFF;
    end else begin
      en_cnt   <= 0;
      pe_valid <= 8'h00;
    end
  end

  // Hard stop in case the sequence below gets stuck somewhere unexpected.
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [5:0] n, input logic r);
    start     = s;
    abort     = a;
    num_cols  = n;
    res_ready = r;
  endtask

  // Runs until done, recording every accepted result, then confirms a single done pulse and idle.
  task automatic collectRun(input string tag, input int budget);
    bit fin = 1'b0;
    int ndone = 0;
    cq.delete();
    bq.delete();
    xq.delete();
    for (int i = 0; i < budget && !fin; i++) begin
      if (res_valid && res_ready) begin
        cq.push_back(res_col);
        bq.push_back(k_bank_sel);
        xq.push_back(x_addr);
      end
      if (done) begin
        ndone++;
        fin = 1'b1;
      end
      step();
    end
    checkOutput({tag, "_finished"}, 32'(fin), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (done) ndone++;
      step();
    end
    checkOutput({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    checkOutput({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit found;
    bit rv_seen;

    // Reset state.
    RESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    step();
    step();
    RESET = 1'b0;
    step();
    checkOutput("reset_outputs",
                {11'd0, pe_enable, col_idx, k_bank_sel, x_addr, res_valid, res_col, busy, done, timeout_err},
                32'd0);

    // 1: two columns, no backpressure.
    pe_lat = 3;
    applyStimulus(1'b1, 1'b0, 6'd2, 1'b1);
    step();
    start = 1'b0;
    checkOutput("t1_enable_after_start", {30'd0, pe_enable, busy}, 32'h3);
    checkOutput("t1_col_start", 32'(col_idx), 32'd0);
    collectRun("t1", 200);
    checkOutput("t1_result_count", 32'(cq.size()), 32'd2);
    if (cq.size() == 2) begin
      checkOutput("t1_col0", {cq[0], bq[0], xq[0]}, {5'd0, 1'b0, 5'd16});
      checkOutput("t1_col1", {cq[1], bq[1], xq[1]}, {5'd1, 1'b1, 5'd16});
    end

    // 2: backpressure on column 0, held longer than the watchdog limit.
    applyStimulus(1'b1, 1'b0, 6'd2, 1'b0);
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (res_valid) found = 1'b1;
      else step();
    end
    checkOutput("t2_result_seen", 32'(found), 32'd1);
    for (int i = 0; i < 20; i++) begin
      checkOutput("t2_hold", {res_valid, res_col, pe_enable, col_idx, timeout_err}, {1'b1, 5'd0, 1'b0, 5'd0, 1'b0});
      step();
    end
    res_ready = 1'b1;
    collectRun("t2", 200);
    checkOutput("t2_result_count", 32'(cq.size()), 32'd2);
    if (cq.size() == 2) begin
      checkOutput("t2_order", {cq[0], cq[1]}, {5'd0, 5'd1});
    end

    // 3: watchdog expiry with one PE never valid.
    pe_model_on = 1'b0;
    pe_stuck = 8'h7F;
    step();
    applyStimulus(1'b1, 1'b0, 6'd1, 1'b1);
    step();
    start = 1'b0;
    rv_seen = res_valid;
    for (int i = 0; i < 15; i++) begin
      step();
      rv_seen |= res_valid;
    end
    checkOutput("t3_before_expiry", {timeout_err, pe_enable, busy}, {1'b0, 1'b1, 1'b1});
    step();
    rv_seen |= res_valid;
    checkOutput("t3_expiry", {timeout_err, pe_enable, done}, {1'b1, 1'b0, 1'b1});
    checkOutput("t3_no_result", 32'(rv_seen), 32'd0);
    step();
    checkOutput("t3_sticky_idle", {timeout_err, busy}, {1'b1, 1'b0});
    pe_model_on = 1'b1;
    step();
    applyStimulus(1'b1, 1'b0, 6'd1, 1'b1);
    step();
    start = 1'b0;
    checkOutput("t3_err_cleared", 32'(timeout_err), 32'd0);
    collectRun("t3_rerun", 200);
    checkOutput("t3_rerun_count", 32'(cq.size()), 32'd1);

    // Abort alone in IDLE, and start together with abort, both leave the scheduler idle.
    applyStimulus(1'b0, 1'b1, 6'd2, 1'b1);
    step();
    checkOutput("idle_abort_ignored", {busy, done}, {1'b0, 1'b0});
    applyStimulus(1'b1, 1'b1, 6'd2, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 6'd2, 1'b1);
    checkOutput("start_with_abort", {busy, pe_enable}, {1'b0, 1'b0});

    // 4: abort while computing column 3.
    applyStimulus(1'b1, 1'b0, 6'd6, 1'b1);
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (col_idx == 5'd3 && pe_enable) found = 1'b1;
      else step();
    end
    checkOutput("t4_reached_col3", 32'(found), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("t4_abort_done", {done, pe_enable, res_valid, busy}, {1'b1, 1'b0, 1'b0, 1'b1});
    step();
    checkOutput("t4_idle_col", {done, busy, col_idx}, {1'b0, 1'b0, 5'd3});
    applyStimulus(1'b1, 1'b0, 6'd1, 1'b1);
    step();
    start = 1'b0;
    checkOutput("t4_restart", {pe_enable, col_idx}, {1'b1, 5'd0});
    collectRun("t4_rerun", 200);

    // 5: reset while presenting column 1, with start held high.
    applyStimulus(1'b1, 1'b0, 6'd3, 1'b1);
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (col_idx == 5'd1 && pe_enable) found = 1'b1;
      else step();
    end
    res_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (res_valid) found = 1'b1;
      else step();
    end
    checkOutput("t5_in_result", {32'(found)}, 32'd1);
    checkOutput("t5_res_col", 32'(res_col), 32'd1);
    RESET = 1'b1;
    start = 1'b1;
    step();
    checkOutput("t5_reset_outputs",
                {11'd0, pe_enable, col_idx, k_bank_sel, x_addr, res_valid, res_col, busy, done, timeout_err},
                32'd0);
    RESET = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b1);
    step();
    checkOutput("t5_stays_idle", 32'(busy), 32'd0);

    // 6: full sweep with num_cols=0 and single-cycle PEs.
    pe_lat = 1;
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b1);
    step();
    start = 1'b0;
    collectRun("t6", 1500);
    checkOutput("t6_result_count", 32'(cq.size()), 32'd32);
    if (cq.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        checkOutput($sformatf("t6_col%0d", i), {cq[i], bq[i], xq[i]},
                    {5'(i), 1'(i % 2), 5'(16 + i / 2)});
      end
      checkOutput("t6_last_xaddr", 32'(xq[31]), 32'd31);
    end
    checkOutput("t6_final_col", 32'(col_idx), 32'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
